riscv_muldiv: RTL and testbench

Iterative multiply/divide unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It sits directly downstream of the register file: it consumes the rs1/rs2 read data and produces a 32-bit result plus destination tag, which the top-level CPU routes to the register-file write port. It runs as a start/busy/done multi-cycle unit and stalls the pipeline while busy.

---
 rtl/riscv_muldiv.sv | 203 ++++++++++++++++++++
 tb/tb_riscv_muldiv.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_muldiv.sv
// riscv_muldiv: iterative RV32M multiply/divide unit (start/busy/done).
// Multiplies use a 32-cycle shift-add loop and divides use 32-cycle restoring
// division on operand magnitudes. A FIX cycle then applies sign correction.
// Divide-by-zero and signed overflow are resolved at the accept edge.
// Optional build macro RISCV_MULDIV_FAST_MUL_EN: all multiplies finish at the
// accept edge through a single combinational signed multiply.
module riscv_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  input  logic            cancel,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t            r_state;
  logic [2:0]        r_op;
  logic [4:0]        r_rd;
  logic [4:0]        r_count;
  logic [XLEN-1:0]   r_opnd;      // multiplicand magnitude or divisor magnitude
  logic [2*XLEN-1:0] r_acc;       // {high/remainder, low/multiplier/quotient}
  logic              r_sign_a;
  logic              r_sign_b;
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_rd_out;
  logic              r_busy;
  logic              r_done;

  // Operand decode at the accept edge
  logic            w_is_div;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_sign_a;
  logic            w_sign_b;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_div_zero;
  logic            w_div_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_result;
  logic            w_fast_hit;
  logic [XLEN-1:0] w_fast_result;

  assign w_is_div   = funct3[2];
  // MUL/MULH/MULHSU treat A as signed; DIV/REM treat both as signed.
  assign w_a_signed = funct3[2] ? ~funct3[0] : (funct3 != 3'b011);
  assign w_b_signed = funct3[2] ? ~funct3[0] : ~funct3[1];
  assign w_sign_a   = w_a_signed & rs1_data[XLEN-1];
  assign w_sign_b   = w_b_signed & rs2_data[XLEN-1];
  assign w_a_mag    = w_sign_a ? -rs1_data : rs1_data;
  assign w_b_mag    = w_sign_b ? -rs2_data : rs2_data;

  assign w_div_zero = w_is_div && (rs2_data == '0);
  assign w_div_ovf  = w_is_div && !funct3[0] &&
                      (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
  assign w_special  = w_div_zero | w_div_ovf;
  // funct3[1] distinguishes REM/REMU from DIV/DIVU
  assign w_special_result = w_div_zero ? (funct3[1] ? rs1_data : '1)
                                       : (funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});

`ifdef RISCV_MULDIV_FAST_MUL_EN
  // Sign-extending both operands to 2*XLEN and keeping the low 2*XLEN bits of
  // the product is the same as a 33x33 signed multiply for every M-ext mode.
  logic [2*XLEN-1:0] w_fast_a;
  logic [2*XLEN-1:0] w_fast_b;
  logic [2*XLEN-1:0] w_fast_prod;
  assign w_fast_a      = {{XLEN{w_sign_a}}, rs1_data};
  assign w_fast_b      = {{XLEN{w_sign_b}}, rs2_data};
  assign w_fast_prod   = w_fast_a * w_fast_b;
  assign w_fast_hit    = ~funct3[2];
  assign w_fast_result = (funct3 == 3'b000) ? w_fast_prod[XLEN-1:0]
                                            : w_fast_prod[2*XLEN-1:XLEN];
`else
  assign w_fast_hit    = 1'b0;
  assign w_fast_result = '0;
`endif

  // One shift-add step: add multiplicand to the high half when the current
  // multiplier bit (acc[0]) is set, then shift the whole accumulator right.
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_opnd : '0)};
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

  // One restoring-division step: shift the next dividend bit into the
  // remainder, subtract the divisor if it fits, and shift the quotient bit in.
  logic [XLEN:0]     w_div_shift;
  logic              w_div_ge;
  logic [XLEN-1:0]   w_div_sub;
  logic [2*XLEN-1:0] w_div_next;
  assign w_div_shift = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_div_ge    = w_div_shift >= {1'b0, r_opnd};
  assign w_div_sub   = w_div_shift[XLEN-1:0] - r_opnd;
  assign w_div_next  = w_div_ge ? {w_div_sub, r_acc[XLEN-2:0], 1'b1}
                                : {w_div_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};

  // Sign correction applied in FIX
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_rem_fix;
  logic [XLEN-1:0]   w_fix_result;
  assign w_prod_fix = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
  assign w_quo_fix  = (r_sign_a ^ r_sign_b) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem_fix  = r_sign_a ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  // Select the architectural result word for the latched op
  always_comb begin
    w_fix_result = '0;
    case (r_op)
      3'b000:                 w_fix_result = w_prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fix_result = w_prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fix_result = w_quo_fix;
      default:                w_fix_result = w_rem_fix;
    endcase
  end

  // Control FSM with registered busy/done/result/rd_out
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_rd     <= '0;
      r_count  <= '0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_result <= '0;
      r_rd_out <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start && !cancel) begin
            r_op <= funct3;
            r_rd <= rd_in;
            if (w_special || w_fast_hit) begin
              r_result <= w_special ? w_special_result : w_fast_result;
              r_rd_out <= rd_in;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_sign_a <= w_sign_a;
              r_sign_b <= w_sign_b;
              // Divide iterates on the dividend with the divisor held aside;
              // multiply iterates on the multiplier with the multiplicand held.
              r_opnd   <= w_is_div ? w_b_mag : w_a_mag;
              r_acc    <= {{XLEN{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
              r_count  <= '0;
              r_busy   <= 1'b1;
              r_state  <= S_CALC;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          if (cancel) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_acc   <= r_op[2] ? w_div_next : w_mul_next;
            r_count <= r_count + 5'd1;
            if (r_count == 5'd31) r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_busy <= 1'b0;
          if (cancel) begin
            r_state <= S_IDLE;
          end else begin
            r_result <= w_fix_result;
            r_rd_out <= r_rd;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign rd_out = r_rd_out;

endmodule

// File: tb/tb_riscv_muldiv.sv
// Testbench for riscv_muldiv: directed vector table plus hand-written
// sequences for ignored start, cancel, mid-op reset and back-to-back ops.
module tb_riscv_muldiv;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_in;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef RISCV_MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  riscv_muldiv #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_in    (rd_in),
    .cancel   (cancel),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .rd_out   (rd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    logic        special;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int exp_latency(input logic [2:0] f3, input logic special);
    if (special || (FAST && !f3[2])) return 1;
    return 34;
  endfunction

  task automatic drive_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
    funct3   = f3;
    rs1_data = a;
    rs2_data = b;
    rd_in    = rd;
  endtask

  // Issue one op and wait (bounded) for its done pulse
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int lat);
    int cyc;
    bit got;
    @(negedge clk);
    drive_op(f3, a, b, rd);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    got = 1'b0;
    while (cyc < 60 && !got) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1 && lat > 1) check({name, " busy"}, {31'd0, busy}, 32'd1);
      if (done) got = 1'b1;
    end
    if (!got) begin
      check({name, " timeout"}, 32'd0, 32'd1);
    end else begin
      check({name, " result"}, result, exp);
      check({name, " rd_out"}, {27'd0, rd_out}, {27'd0, rd});
      check({name, " latency"}, cyc, lat);
      check({name, " busy@done"}, {31'd0, busy}, 32'd0);
      @(negedge clk);
      check({name, " done pulse width"}, {31'd0, done}, 32'd0);
    end
    $display("op %-10s f3=%b a=%08h b=%08h rd=%0d -> result=%08h rd_out=%0d cycles=%0d",
             name, f3, a, b, rd, result, rd_out, cyc);
  endtask

  initial begin
    int cyc;
    int done_cnt;
    int t1;
    int t2;

    vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 1'b0};
    vecs[2]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'h00000000, 1'b0};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'd2,        5'd4,  32'hFFFFFFFF, 1'b0};
    vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        5'd5,  32'hFFFFFFFD, 1'b0};
    vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, 1'b0};
    vecs[6]  = '{3'b101, 32'd100,      32'd7,        5'd7,  32'd14,       1'b0};
    vecs[7]  = '{3'b111, 32'd100,      32'd7,        5'd8,  32'd2,        1'b0};
    vecs[8]  = '{3'b101, 32'd5,        32'd0,        5'd9,  32'hFFFFFFFF, 1'b1};
    vecs[9]  = '{3'b110, 32'd5,        32'd0,        5'd10, 32'd5,        1'b1};
    vecs[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1'b1};
    vecs[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h00000000, 1'b1};
    vecs[12] = '{3'b011, 32'h80000000, 32'd4,        5'd13, 32'h00000002, 1'b0};
    vecs[13] = '{3'b001, 32'h80000000, 32'h80000000, 5'd14, 32'h40000000, 1'b0};
    vecs[14] = '{3'b100, 32'h7FFFFFFF, 32'hFFFFFFFF, 5'd15, 32'h80000001, 1'b0};
    vecs[15] = '{3'b110, 32'hFFFFFFF9, 32'hFFFFFFFE, 5'd16, 32'hFFFFFFFF, 1'b0};

    rst = 1'b1;
    start = 1'b0;
    cancel = 1'b0;
    drive_op(3'b000, 32'd0, 32'd0, 5'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset rd_out", {27'd0, rd_out}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd,
             vecs[i].exp, exp_latency(vecs[i].f3, vecs[i].special));
    end

    // Start while busy must be ignored
    @(negedge clk);
    drive_op(3'b100, 32'd100, 32'd7, 5'd3);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    t1 = 0;
    while (cyc < 60 && t1 == 0) begin
      @(negedge clk);
      cyc++;
      if (done) t1 = cyc;
      if (cyc == 5) begin
        drive_op(3'b101, 32'd5, 32'd0, 5'd9);
        start = 1'b1;
      end else if (cyc == 6) begin
        start = 1'b0;
      end
    end
    check("ignored-start latency", t1, 34);
    check("ignored-start result", result, 32'd14);
    check("ignored-start rd_out", {27'd0, rd_out}, 32'd3);
    $display("seq ignored-start -> result=%08h rd_out=%0d cycles=%0d", result, rd_out, t1);

    // Cancel mid-divide
    @(negedge clk);
    drive_op(3'b100, 32'd1000, 32'd3, 5'd4);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_cnt = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (c == 10) cancel = 1'b1;
      if (c == 11) begin
        cancel = 1'b0;
        check("cancel busy", {31'd0, busy}, 32'd0);
        check("cancel done", {31'd0, done}, 32'd0);
        check("cancel result kept", result, 32'd14);
        check("cancel rd_out kept", {27'd0, rd_out}, 32'd3);
      end
    end
    check("cancel no done pulse", done_cnt, 0);
    $display("seq cancel -> busy=%0d result=%08h done_pulses=%0d", busy, result, done_cnt);

    // Reset in the middle of a multiply
    @(negedge clk);
    drive_op(3'b000, 32'd7, 32'd3, 5'd5);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midop-rst busy", {31'd0, busy}, 32'd0);
    check("midop-rst done", {31'd0, done}, 32'd0);
    check("midop-rst result", result, 32'd0);
    check("midop-rst rd_out", {27'd0, rd_out}, 32'd0);
    rst = 1'b0;
    $display("seq midop-rst -> busy=%0d done=%0d result=%08h rd_out=%0d", busy, done, result, rd_out);
    run_op("post-rst", 3'b101, 32'd100, 32'd7, 5'd6, 32'd14, 34);

    // Back-to-back: start held through the first done cycle
    @(negedge clk);
    drive_op(3'b101, 32'd100, 32'd7, 5'd10);
    start = 1'b1;
    @(posedge clk);
    #1 drive_op(3'b101, 32'd1000, 32'd10, 5'd11);
    cyc = 0;
    t1 = 0;
    t2 = 0;
    while (cyc < 100 && t2 == 0) begin
      @(negedge clk);
      cyc++;
      if (t1 != 0 && cyc == t1 + 1) begin
        start = 1'b0;
        check("b2b second busy", {31'd0, busy}, 32'd1);
      end
      if (done) begin
        if (t1 == 0) begin
          t1 = cyc;
          check("b2b first result", result, 32'd14);
          check("b2b first rd_out", {27'd0, rd_out}, 32'd10);
        end else begin
          t2 = cyc;
          check("b2b second result", result, 32'd100);
          check("b2b second rd_out", {27'd0, rd_out}, 32'd11);
        end
      end
    end
    start = 1'b0;
    check("b2b first latency", t1, 34);
    check("b2b spacing", t2 - t1, 34);
    $display("seq back-to-back -> first done @%0d, second done @%0d, result=%08h rd_out=%0d",
             t1, t2, result, rd_out);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
